rank_filter_3x3: RTL and testbench
==================================

# rank_filter_3x3

Parametrised 3x3 rank filter for the grayscale video path; the next generation of the fixed 8-bit median stage. Takes a vsync/href pixel stream, builds a 3x3 window from two internal line buffers with edge replication, and outputs median, min, max or bypass per frame. After the input frame ends it self-generates a flush line so the output frame has exactly the same dimensions as the input. A sticky line-length check is also provided.

## Interface
- DATA_WIDTH, 8, pixel bit width
- IMG_HDISP, 640, active pixels per line; line buffer depth
- IMG_VDISP, 480, active lines per frame; sizes the row counter
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  0 bypass (centre pixel), 1 median, 2 min, 3 max; sampled on per_img_vsync rising edge, held for the frame
- per_img_vsync  in  1  input frame valid
- per_img_href  in  1  input pixel valid
- per_img_gray  in  DATA_WIDTH  input pixel
- post_img_vsync  out  1  output frame valid
- post_img_href  out  1  output pixel valid
- post_img_gray  out  DATA_WIDTH  filtered pixel
- line_len_err  out  1  sticky: some input line length != IMG_HDISP; cleared on per_img_vsync rising edge

## Operation
- FSM states: IDLE, ACTIVE, FLUSH.
  - IDLE -> ACTIVE on per_img_vsync rising edge. At this transition: latch mode, clear row/col counters, clear line_len_err.
  - ACTIVE -> FLUSH on per_img_vsync falling edge.
  - FLUSH -> IDLE after IMG_HDISP internal flush pixels.
- Internal stream:
  - In ACTIVE, the stream is the input href/pixel.
  - In FLUSH, the block drives an internal href high for IMG_HDISP consecutive cycles, starting 2 cycles after per_img_vsync falls. Flush pixel data is don't-care.
- vsync_int = per_img_vsync OR (state == FLUSH).
- Line buffers: two IMG_HDISP x DATA_WIDTH shift buffers, written on every stream href.
  - Input row 0 only fills the buffers and produces no output.
  - Stream row k (k >= 1, including the flush row) produces output row k-1.
- Window for output (r,c) is rows r-1..r+1 and cols c-1..c+1, with edge replication:
  - row -1 -> row 0; row H -> row H-1, where H is the number of rows actually received;
  - col -1 -> col 0; col IMG_HDISP -> col IMG_HDISP-1.
- Rank computation:
  - median: 3-stage sort network (sort each row; max-of-mins / med-of-meds / min-of-maxes; median of those three);
  - min and max: over all 9 window pixels;
  - bypass: centre pixel.
  - All modes use identical pipeline latency.
- line_len_err is set when an href burst ends with a column count != IMG_HDISP. It applies to input lines only; the flush line is excluded.
- Input vsync falling before IMG_VDISP rows: flush still runs, and the bottom edge replicates the last row actually received.
- per_img_vsync rising while in FLUSH: ignored. The frame is not started and the input is dropped until IDLE.
- Reset, asserted at any time:
  - all outputs 0, FSM IDLE, counters 0;
  - line buffer contents are don't-care;
  - the next frame begins only on a fresh vsync rising edge.

## Timing
- Latency: post_img_href/post_img_gray equal the qualified stream href/window result delayed exactly 5 clk. Qualified stream href = stream href AND stream row >= 1.
- post_img_vsync = vsync_int delayed exactly 5 clk.
- Output row r is emitted during stream row r+1. The last output row is emitted during the flush line.
- Output pixel count per frame = IMG_HDISP x H.
- Input constraints:
  - href low >= 2 cycles between lines;
  - per_img_vsync low >= IMG_HDISP + 8 cycles between frames (flush plus pipeline drain).
- Reset values: post_img_vsync = 0, post_img_href = 0, post_img_gray = 0, line_len_err = 0.
- mode changes mid-frame have no effect until the next vsync rising edge.

## Test plan
All tests use IMG_HDISP = 8, IMG_VDISP = 4, DATA_WIDTH = 8 unless stated otherwise.
- Constant 0x55 frame, mode = 1 -> 32 output pixels, all 0x55. First post_img_href rises exactly 5 clk after input row 1 href rises. Last output row occurs during the flush line.
- 0x10 field with a single 0xFF at (1,3):
  - mode = 1 -> all outputs 0x10;
  - mode = 3 -> 0xFF exactly at rows 0..2, cols 2..4, 0x10 elsewhere;
  - mode = 2 -> all 0x10.
- Horizontal ramp, pixel = col*16, mode = 1 -> every row outputs 00,10,20,...,70, confirming edge replication. Same ramp with mode = 0 -> identical output.
- Input line 2 with 7 pixels -> line_len_err = 1 and stays high until the next frame's vsync rising edge, then 0.
- mode switched from 1 to 3 mid-frame -> the current frame stays median; the next frame outputs max.
- rst_n pulsed low mid-row 2 -> outputs 0 within the reset cycle. A following full frame of 0x33 outputs 32 pixels of 0x33 with correct dimensions; 4 rows early vsync fall -> 3-row input yields 24 output pixels.

Source files
------------

// File: rtl/rank_filter_3x3_if.sv
// Pixel stream bundle for the rank filter: per_* enters the filter, post_* leaves it.
interface rank_filter_3x3_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  per_img_vsync;
    logic                  per_img_href;
    logic [DATA_WIDTH-1:0] per_img_gray;
    logic                  post_img_vsync;
    logic                  post_img_href;
    logic [DATA_WIDTH-1:0] post_img_gray;

    modport master (
        output per_img_vsync, per_img_href, per_img_gray,
        input  post_img_vsync, post_img_href, post_img_gray
    );
    modport slave (
        input  per_img_vsync, per_img_href, per_img_gray,
        output post_img_vsync, post_img_href, post_img_gray
    );
endinterface

// File: rtl/rank_filter_3x3.sv
// 3x3 rank filter (bypass/median/min/max) over a vsync/href pixel stream with edge
// replication; a self-generated flush line emits the last output row of each frame.
module rank_filter_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    rank_filter_3x3_if.slave vid,
    output logic             line_len_err
);
    localparam int CW = $clog2(IMG_HDISP + 2);
    localparam int RW = $clog2(IMG_VDISP + 2);
    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_HDISP);
    localparam logic [CW-1:0] COL_SAT  = CW'(IMG_HDISP + 1);
    localparam logic [RW-1:0] ROW_SAT  = RW'(IMG_VDISP + 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(IMG_HDISP - 1);

    typedef logic [DATA_WIDTH-1:0] pix_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction
    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction
    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction
    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction
    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t        state_q, state_d;
    logic          vs_prev_q, vs_prev_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          href_d1_q, href_d1_d;
    logic          err_q, err_d;

    logic          vs_rise_s, vs_fall_s, start_s, href_s, flush_s, eob_s;
    logic          qhref_s, we_s;
    logic [AW-1:0] rd_addr_s;
    pix_t          gray_s, tap1_s, tap2_s;
    pix_t          lb1_q [IMG_HDISP];
    pix_t          lb2_q [IMG_HDISP];

    // Column vectors are {top, mid, bottom}; a is the newest column, c the oldest.
    pix_t col_a_q [3], col_a_d [3];
    pix_t col_b_q [3], col_b_d [3];
    pix_t col_c_q [3], col_c_d [3];
    logic v_a_q, v_a_d, v_b_q, v_b_d, v_c_q, v_c_d;
    pix_t win_l_s [3], win_r_s [3];
    pix_t lo1_q [3], lo1_d [3], md1_q [3], md1_d [3], hi1_q [3], hi1_d [3];
    pix_t ctr1_q, ctr1_d, ctr2_q, ctr2_d;
    logic v1_q, v1_d, v2_q, v2_d;
    pix_t mxmn_q, mxmn_d, mdmd_q, mdmd_d, mnmx_q, mnmx_d, mnall_q, mnall_d, mxall_q, mxall_d;
    logic       v_out_q, v_out_d;
    pix_t       gray_out_q, gray_out_d;
    logic [4:0] vs_pipe_q, vs_pipe_d;

    assign vs_rise_s = vid.per_img_vsync & ~vs_prev_q;
    assign vs_fall_s = ~vid.per_img_vsync & vs_prev_q;

    // Frame FSM: selects the stream source and times the flush line
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fcnt_d  = '0;
        href_s  = 1'b0;
        flush_s = 1'b0;
        start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (vs_rise_s) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                href_s = vid.per_img_href;
                if (vs_fall_s) begin
                    state_d = FLUSH;
                end else begin
                    state_d = ACTIVE;
                end
            end
            FLUSH: begin
                // One idle cycle, then IMG_HDISP cycles of internal href.
                flush_s = 1'b1;
                href_s  = (fcnt_q != '0);
                if (fcnt_q == COL_LAST) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row/column counters and the sticky line-length check
    always_comb begin
        vs_prev_d = vid.per_img_vsync;
        href_d1_d = href_s;
        eob_s     = href_d1_q & ~href_s;
        if (href_s) begin
            col_d = (col_q == COL_SAT) ? col_q : col_q + CW'(1);
        end else begin
            col_d = '0;
        end
        if (state_q == IDLE) begin
            row_d = '0;
        end else if (eob_s && (row_q != ROW_SAT)) begin
            row_d = row_q + RW'(1);
        end else begin
            row_d = row_q;
        end
        if (start_s) begin
            err_d = 1'b0;
        end else if ((state_q == ACTIVE) && eob_s && (col_q != COL_LAST)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Line-buffer taps and vertical edge replication for the incoming column
    always_comb begin
        gray_s     = (state_q == ACTIVE) ? vid.per_img_gray : '0;
        rd_addr_s  = (col_q < COL_LAST) ? col_q[AW-1:0] : ADDR_MAX;
        tap1_s     = lb1_q[rd_addr_s];
        tap2_s     = lb2_q[rd_addr_s];
        we_s       = href_s & (col_q < COL_LAST);
        qhref_s    = href_s & (row_q != '0);
        col_a_d[0] = (row_q == RW'(1)) ? tap1_s : tap2_s;
        col_a_d[1] = tap1_s;
        col_a_d[2] = flush_s ? tap1_s : gray_s;
        v_a_d      = qhref_s;
        col_b_d    = col_a_q;
        col_c_d    = col_b_q;
        v_b_d      = v_a_q;
        v_c_d      = v_b_q;
    end

    // Horizontal replication and the three rank stages
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_l_s[i] = v_c_q ? col_c_q[i] : col_b_q[i];
            win_r_s[i] = v_a_q ? col_a_q[i] : col_b_q[i];
            lo1_d[i]   = min3(win_l_s[i], col_b_q[i], win_r_s[i]);
            md1_d[i]   = med3(win_l_s[i], col_b_q[i], win_r_s[i]);
            hi1_d[i]   = max3(win_l_s[i], col_b_q[i], win_r_s[i]);
        end
        ctr1_d  = col_b_q[1];
        v1_d    = v_b_q;
        mxmn_d  = max3(lo1_q[0], lo1_q[1], lo1_q[2]);
        mdmd_d  = med3(md1_q[0], md1_q[1], md1_q[2]);
        mnmx_d  = min3(hi1_q[0], hi1_q[1], hi1_q[2]);
        mnall_d = min3(lo1_q[0], lo1_q[1], lo1_q[2]);
        mxall_d = max3(hi1_q[0], hi1_q[1], hi1_q[2]);
        ctr2_d  = ctr1_q;
        v2_d    = v1_q;
        v_out_d = v2_q;
        case (mode_q)
            2'd0:    gray_out_d = ctr2_q;
            2'd1:    gray_out_d = med3(mxmn_q, mdmd_q, mnmx_q);
            2'd2:    gray_out_d = mnall_q;
            2'd3:    gray_out_d = mxall_q;
            default: gray_out_d = ctr2_q;
        endcase
        if (!v2_q) begin
            gray_out_d = '0;
        end else begin
            gray_out_d = gray_out_d;
        end
        vs_pipe_d = {vs_pipe_q[3:0], vid.per_img_vsync | flush_s};
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vs_prev_q <= 1'b1;
            mode_q    <= 2'd0;
            col_q     <= '0;
            row_q     <= '0;
            fcnt_q    <= '0;
            href_d1_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vs_prev_d;
            mode_q    <= mode_d;
            col_q     <= col_d;
            row_q     <= row_d;
            fcnt_q    <= fcnt_d;
            href_d1_q <= href_d1_d;
            err_q     <= err_d;
        end
    end

    // Line buffers: contents need no reset since row 0 of every frame refills them
    always_ff @(posedge clk) begin
        if (we_s) begin
            lb1_q[rd_addr_s] <= gray_s;
            lb2_q[rd_addr_s] <= tap1_s;
        end
    end

    // Window and rank pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                col_a_q[i] <= '0;
                col_b_q[i] <= '0;
                col_c_q[i] <= '0;
                lo1_q[i]   <= '0;
                md1_q[i]   <= '0;
                hi1_q[i]   <= '0;
            end
            v_a_q      <= 1'b0;
            v_b_q      <= 1'b0;
            v_c_q      <= 1'b0;
            ctr1_q     <= '0;
            ctr2_q     <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            mxmn_q     <= '0;
            mdmd_q     <= '0;
            mnmx_q     <= '0;
            mnall_q    <= '0;
            mxall_q    <= '0;
            v_out_q    <= 1'b0;
            gray_out_q <= '0;
            vs_pipe_q  <= 5'd0;
        end else begin
            col_a_q    <= col_a_d;
            col_b_q    <= col_b_d;
            col_c_q    <= col_c_d;
            lo1_q      <= lo1_d;
            md1_q      <= md1_d;
            hi1_q      <= hi1_d;
            v_a_q      <= v_a_d;
            v_b_q      <= v_b_d;
            v_c_q      <= v_c_d;
            ctr1_q     <= ctr1_d;
            ctr2_q     <= ctr2_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            mxmn_q     <= mxmn_d;
            mdmd_q     <= mdmd_d;
            mnmx_q     <= mnmx_d;
            mnall_q    <= mnall_d;
            mxall_q    <= mxall_d;
            v_out_q    <= v_out_d;
            gray_out_q <= gray_out_d;
            vs_pipe_q  <= vs_pipe_d;
        end
    end

    assign vid.post_img_vsync = vs_pipe_q[4];
    assign vid.post_img_href  = v_out_q;
    assign vid.post_img_gray  = gray_out_q;
    assign line_len_err       = err_q;
endmodule

// File: tb/tb_rank_filter_3x3.sv
// Randomised and directed bench for rank_filter_3x3 against a sort-based 3x3 window model.
module tb_rank_filter_3x3;
    localparam int HD = 8;
    localparam int VD = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          line_len_err;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] img [VD][HD];
    logic [DW-1:0] mon_val [$];
    int            mon_cyc [$];
    logic          mon_vs [$];

    rank_filter_3x3_if #(.DATA_WIDTH(DW)) vid ();

    rank_filter_3x3 #(.DATA_WIDTH(DW), .IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .vid(vid), .line_len_err(line_len_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vid.post_img_href === 1'b1) begin
            mon_val.push_back(vid.post_img_gray);
            mon_cyc.push_back(cyc);
            mon_vs.push_back(vid.post_img_vsync);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 constant, 1 impulse at (1,3) on background v, 2 ramp col*16, 3 random
    task automatic fill(input int kind, input logic [DW-1:0] v);
        for (int r = 0; r < VD; r++) begin
            for (int c = 0; c < HD; c++) begin
                case (kind)
                    0: img[r][c] = v;
                    1: img[r][c] = (r == 1 && c == 3) ? 8'hFF : v;
                    2: img[r][c] = DW'(c * 16);
                    default: img[r][c] = DW'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    function automatic logic [DW-1:0] ref_pix(input int r, input int c, input int h, input int md);
        logic [DW-1:0] w [9];
        logic [DW-1:0] t;
        int k;
        int rr;
        int cc;
        k = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr < 0) rr = 0;
                if (rr > h - 1) rr = h - 1;
                if (cc < 0) cc = 0;
                if (cc > HD - 1) cc = HD - 1;
                w[k] = img[rr][cc];
                k++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (w[j] > w[j+1]) begin
                    t = w[j]; w[j] = w[j+1]; w[j+1] = t;
                end
            end
        end
        case (md)
            0: return img[r][c];
            1: return w[4];
            2: return w[0];
            default: return w[8];
        endcase
    endfunction

    task automatic run_frame(input int nrows, input int md0, input int md_mid,
                             input int short_row, input bit check_pix, input string tag);
        int t_in [VD][HD];
        int f_cyc;
        int len;
        int n;
        int r;
        int c;
        int exp_t;
        logic [DW-1:0] exp_v;
        mon_val.delete(); mon_cyc.delete(); mon_vs.delete();
        tick();
        mode = 2'(md0);
        vid.per_img_vsync = 1'b1;
        repeat (3) tick();
        for (int rr = 0; rr < nrows; rr++) begin
            len = (rr == short_row) ? HD - 1 : HD;
            for (int cc = 0; cc < len; cc++) begin
                tick();
                vid.per_img_href = 1'b1;
                vid.per_img_gray = img[rr][cc];
                t_in[rr][cc] = cyc;
            end
            tick();
            vid.per_img_href = 1'b0;
            vid.per_img_gray = '0;
            if (rr == 1 && md_mid >= 0) mode = 2'(md_mid);
            repeat (2) tick();
        end
        tick();
        vid.per_img_vsync = 1'b0;
        f_cyc = cyc;
        repeat (HD + 12) tick();
        if (check_pix) begin
            checks++;
            if (mon_val.size() != nrows * HD) begin
                errors++;
                $display("FAIL %s count: got %0d expected %0d", tag, mon_val.size(), nrows * HD);
            end
            n = (mon_val.size() < nrows * HD) ? mon_val.size() : nrows * HD;
            for (int i = 0; i < n; i++) begin
                r = i / HD;
                c = i % HD;
                exp_v = ref_pix(r, c, nrows, md0);
                exp_t = (r + 1 < nrows) ? t_in[r+1][c] + 5 : f_cyc + 2 + c + 5;
                checks++;
                if (mon_val[i] !== exp_v) begin
                    errors++;
                    $display("FAIL %s pix r%0d c%0d: got %02h expected %02h", tag, r, c, mon_val[i], exp_v);
                end
                checks++;
                if (mon_cyc[i] != exp_t) begin
                    errors++;
                    $display("FAIL %s time r%0d c%0d: got %0d expected %0d", tag, r, c, mon_cyc[i], exp_t);
                end
                checks++;
                if (mon_vs[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s vsync r%0d c%0d: got %b expected 1", tag, r, c, mon_vs[i]);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (vid.post_img_vsync !== 1'b0 || vid.post_img_href !== 1'b0 ||
            vid.post_img_gray !== '0 || line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got vs=%b href=%b gray=%02h err=%b expected all 0", tag,
                     vid.post_img_vsync, vid.post_img_href, vid.post_img_gray, line_len_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'd0;
        vid.per_img_vsync = 1'b0;
        vid.per_img_href  = 1'b0;
        vid.per_img_gray  = '0;
        repeat (3) tick();
        check_outputs_zero("reset_in");
        rst_n = 1'b1;
        repeat (4) tick();
        check_outputs_zero("reset_after");
    endtask

    task automatic test_const();
        fill(0, 8'h55);
        run_frame(VD, 1, -1, -1, 1'b1, "const55");
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL const55 err: got %b expected 0", line_len_err);
        end
    endtask

    task automatic test_impulse();
        int ff;
        int exp_ff;
        for (int m = 1; m <= 3; m++) begin
            fill(1, 8'h10);
            run_frame(VD, m, -1, -1, 1'b1, "impulse");
            exp_ff = (m == 3) ? 9 : 0;
            ff = 0;
            foreach (mon_val[i]) if (mon_val[i] == 8'hFF) ff++;
            checks++;
            if (ff != exp_ff) begin
                errors++;
                $display("FAIL impulse ff_count mode %0d: got %0d expected %0d", m, ff, exp_ff);
            end
        end
    endtask

    task automatic test_ramp();
        fill(2, 8'h00);
        run_frame(VD, 1, -1, -1, 1'b1, "ramp_med");
        run_frame(VD, 0, -1, -1, 1'b1, "ramp_byp");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            fill(3, 8'h00);
            run_frame($urandom_range(1, VD), $urandom_range(0, 3), -1, -1, 1'b1, "random");
        end
    endtask

    task automatic test_line_len();
        fill(0, 8'h20);
        run_frame(VD, 1, -1, 2, 1'b0, "short");
        checks++;
        if (line_len_err !== 1'b1) begin
            errors++;
            $display("FAIL line_len set: got %b expected 1", line_len_err);
        end
        repeat (10) tick();
        checks++;
        if (line_len_err !== 1'b1) begin
            errors++;
            $display("FAIL line_len sticky: got %b expected 1", line_len_err);
        end
        run_frame(VD, 1, -1, -1, 1'b1, "after_short");
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL line_len clear: got %b expected 0", line_len_err);
        end
    endtask

    task automatic test_mode_switch();
        fill(1, 8'h10);
        run_frame(VD, 1, 3, -1, 1'b1, "switch_cur");
        run_frame(VD, 3, -1, -1, 1'b1, "switch_next");
    endtask

    task automatic test_reset_mid();
        fill(3, 8'h00);
        tick();
        mode = 2'd1;
        vid.per_img_vsync = 1'b1;
        repeat (3) tick();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < ((r == 2) ? 6 : HD); c++) begin
                tick();
                vid.per_img_href = 1'b1;
                vid.per_img_gray = img[r][c];
            end
            if (r < 2) begin
                tick();
                vid.per_img_href = 1'b0;
                repeat (2) tick();
            end
        end
        checks++;
        if (vid.post_img_href !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre href: got %b expected 1", vid.post_img_href);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        vid.per_img_href = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        mon_val.delete(); mon_cyc.delete(); mon_vs.delete();
        repeat (5) tick();
        vid.per_img_vsync = 1'b0;
        repeat (HD + 12) tick();
        checks++;
        if (mon_val.size() != 0) begin
            errors++;
            $display("FAIL rst_mid stale frame: got %0d pixels expected 0", mon_val.size());
        end
        fill(0, 8'h33);
        run_frame(VD, 1, -1, -1, 1'b1, "rst_full");
        run_frame(3, 1, -1, -1, 1'b1, "early_vs");
    endtask

    initial begin
        test_reset();
        test_const();
        test_impulse();
        test_ramp();
        test_line_len();
        test_mode_switch();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
